// File: rtl/wb2core.sv
// Wishbone B4 pipelined slave to core-style req/gnt/rvalid bridge.
// One-entry request register, in-flight credit counter, abandon/drain on early cycle drop.
module wb2core #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_cyc,
    input  logic            wb_stb,
    input  logic            wb_we,
    input  logic [DW/8-1:0] wb_sel,
    input  logic [AW-1:0]   wb_adr,
    input  logic [DW-1:0]   wb_dat_i,
    output logic            wb_stall,
    output logic            wb_ack,
    output logic            wb_err,
    output logic [DW-1:0]   wb_dat_o,
    output logic            core_req,
    output logic            core_we,
    output logic [DW/8-1:0] core_be,
    output logic [AW-1:0]   core_addr,
    output logic [DW-1:0]   core_wdata,
    input  logic            core_gnt,
    input  logic            core_rvalid,
    input  logic [DW-1:0]   core_rdata,
    input  logic            core_err
);

    localparam int unsigned   CW     = $clog2(MaxOutstanding + 1);
    localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

    logic            req_valid_q, req_valid_d;
    logic            we_q;
    logic [DW/8-1:0] be_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [CW-1:0]   pending_q, pending_d;
    logic            abandon_q, abandon_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q;
    logic            accept;
    logic            rsp_ok;

    always_comb begin
        wb_stall = (req_valid_q & ~core_gnt) | ((pending_q == MaxCnt) & ~core_rvalid) | abandon_q;
        accept   = wb_cyc & wb_stb & ~wb_stall;
        // Responses with nothing in flight are protocol violations and are dropped.
        rsp_ok   = core_rvalid & (pending_q != '0);

        pending_d = pending_q;
        if (accept && !rsp_ok) begin
            pending_d = pending_q + CW'(1);
        end else if (!accept && rsp_ok) begin
            pending_d = pending_q - CW'(1);
        end

        // Once the master drops the cycle, drain every outstanding response silently.
        abandon_d   = (abandon_q | ~wb_cyc) & (pending_d != '0);
        req_valid_d = accept | (req_valid_q & ~core_gnt);
        ack_d       = rsp_ok & ~core_err & ~abandon_q & wb_cyc;
        err_d       = rsp_ok & core_err & ~abandon_q & wb_cyc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            pending_q   <= '0;
            abandon_q   <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            req_valid_q <= req_valid_d;
            pending_q   <= pending_d;
            abandon_q   <= abandon_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            if (accept) begin
                we_q    <= wb_we;
                be_q    <= wb_sel;
                addr_q  <= wb_adr;
                wdata_q <= wb_dat_i;
            end
            if (rsp_ok) begin
                rdata_q <= core_rdata;
            end
        end
    end

    assign core_req   = req_valid_q;
    assign core_we    = we_q;
    assign core_be    = be_q;
    assign core_addr  = addr_q;
    assign core_wdata = wdata_q;
    assign wb_ack     = ack_q;
    assign wb_err     = err_q;
    assign wb_dat_o   = rdata_q;

endmodule
